// File: rtl/noc_resp_axilite_pkg.sv
// Shared definitions for the NoC response to AXI-Lite bridge: FSM states,
// AXI response codes, NoC header field positions, message type codes,
// beat-count derivation and a byte-swap helper.
package noc_resp_axilite_pkg;

  typedef enum logic {ST_HDR, ST_DATA} state_e;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  // Header field positions shared by every NoC agent
  localparam int MSG_TYPE_LO   = 14;
  localparam int MSG_TYPE_W    = 8;
  localparam int MSG_LENGTH_LO = 22;
  localparam int MSG_LENGTH_W  = 8;

  localparam logic [MSG_TYPE_W-1:0] MSG_LOAD_MEM_ACK  = 8'd24;
  localparam logic [MSG_TYPE_W-1:0] MSG_STORE_MEM_ACK = 8'd25;

  // Number of NoC flits that make up one AXI data word
  function automatic int calc_beats(input int axi_w, input int noc_w);
    return axi_w / noc_w;
  endfunction

  localparam int SWAP_MAX_W = 1024;

  // Reverse the lowest nbytes bytes of d; bytes above nbytes come back zero
  function automatic logic [SWAP_MAX_W-1:0] byte_swap(input logic [SWAP_MAX_W-1:0] d,
                                                      input int nbytes);
    logic [SWAP_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < SWAP_MAX_W/8; i++) begin
      if (i < nbytes) r[i*8 +: 8] = d[(nbytes-1-i)*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/noc_resp_fifo.sv
// Synchronous first-word-fall-through FIFO. Head entry is visible on
// pop_data_o whenever the FIFO is non-empty; the output reads zero when empty.
module noc_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; push and pop may happen together
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage, no reset needed: contents are masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/noc_resp_axilite_bridge.sv
// NoC memory-response packets to AXI-Lite R and B channels.
// Load acks assemble up to BEATS payload flits into one R word; store acks
// produce a B entry on their header. R and B are queued independently.
// Optional build macro NOCRESP_ENDIAN_SWAP_EN byte-reverses each payload flit.
module noc_resp_axilite_bridge
  import noc_resp_axilite_pkg::*;
#(
  parameter int NOC_DATA_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int AXI_RESP_WIDTH = 2,
  parameter int R_FIFO_DEPTH   = 4,
  parameter int B_FIFO_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      noc_valid_in,
  input  logic [NOC_DATA_WIDTH-1:0] noc_data_in,
  output logic                      noc_ready_out,
  output logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  output logic [AXI_RESP_WIDTH-1:0] m_axi_rresp,
  output logic                      m_axi_rvalid,
  input  logic                      m_axi_rready,
  output logic [AXI_RESP_WIDTH-1:0] m_axi_bresp,
  output logic                      m_axi_bvalid,
  input  logic                      m_axi_bready
);
  localparam int BEATS = calc_beats(AXI_DATA_WIDTH, NOC_DATA_WIDTH);
  localparam int RW    = AXI_DATA_WIDTH + AXI_RESP_WIDTH;

  state_e                    state_q;
  logic [MSG_TYPE_W-1:0]     type_q;
  logic [MSG_LENGTH_W-1:0]   len_q, cnt_q;
  logic                      err_q;
  logic [AXI_DATA_WIDTH-1:0] beat_q, beat_d;

  logic [MSG_TYPE_W-1:0]     hdr_type;
  logic [MSG_LENGTH_W-1:0]   hdr_len;
  logic [NOC_DATA_WIDTH-1:0] flit_d;
  logic                      accept, last_flit;
  logic                      r_full, r_empty, b_full, b_empty;
  logic                      r_push, b_push;
  logic [RW-1:0]             r_push_data, r_pop_data;

  assign hdr_type = noc_data_in[MSG_TYPE_LO +: MSG_TYPE_W];
  assign hdr_len  = noc_data_in[MSG_LENGTH_LO +: MSG_LENGTH_W];

`ifdef NOCRESP_ENDIAN_SWAP_EN
  logic [SWAP_MAX_W-1:0] swap_in, swap_out;
  logic                  unused_swap_bits;
  // Widen the flit to the helper's width, reverse it, keep the low lane
  always_comb begin
    swap_in = '0;
    swap_in[NOC_DATA_WIDTH-1:0] = noc_data_in;
  end
  assign swap_out         = byte_swap(swap_in, NOC_DATA_WIDTH/8);
  assign flit_d           = swap_out[NOC_DATA_WIDTH-1:0];
  assign unused_swap_bits = ^swap_out;
`else
  assign flit_d = noc_data_in;
`endif

  // Header needs room for the single entry its packet may produce;
  // payload is always sunk since that room was reserved at header time.
  assign noc_ready_out = (state_q == ST_HDR) ? (!r_full && !b_full) : 1'b1;
  assign accept        = noc_valid_in && noc_ready_out;
  assign last_flit     = (state_q == ST_DATA) && (cnt_q == len_q - 1'b1);

  // Merge the current payload flit into its lane; overflow flits fall off
  always_comb begin
    beat_d = beat_q;
    if (state_q == ST_DATA && type_q == MSG_LOAD_MEM_ACK) begin
      for (int b = 0; b < BEATS; b++) begin
        if (int'(cnt_q) == b) beat_d[b*NOC_DATA_WIDTH +: NOC_DATA_WIDTH] = flit_d;
      end
    end
  end

  // Response pushes: zero-length load on the header, otherwise on last flit
  always_comb begin
    r_push      = 1'b0;
    b_push      = 1'b0;
    r_push_data = {{AXI_DATA_WIDTH{1'b0}}, AXI_RESP_WIDTH'(AXI_OKAY)};
    if (accept && state_q == ST_HDR) begin
      r_push = (hdr_type == MSG_LOAD_MEM_ACK) && (hdr_len == '0);
      b_push = (hdr_type == MSG_STORE_MEM_ACK);
    end else if (accept && last_flit && type_q == MSG_LOAD_MEM_ACK) begin
      r_push      = 1'b1;
      r_push_data = {beat_d, err_q ? AXI_RESP_WIDTH'(AXI_SLVERR) : AXI_RESP_WIDTH'(AXI_OKAY)};
    end
  end

  // Packet parser FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HDR;
      type_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      beat_q  <= '0;
    end else if (accept) begin
      case (state_q)
        ST_HDR: begin
          type_q <= hdr_type;
          len_q  <= hdr_len;
          cnt_q  <= '0;
          beat_q <= '0;
          err_q  <= int'(hdr_len) > BEATS;
          if (hdr_len != '0) state_q <= ST_DATA;
        end
        ST_DATA: begin
          beat_q <= beat_d;
          cnt_q  <= cnt_q + 1'b1;
          if (last_flit) state_q <= ST_HDR;
        end
        default: state_q <= ST_HDR;
      endcase
    end
  end

  noc_resp_fifo #(.WIDTH(RW), .DEPTH(R_FIFO_DEPTH)) u_r_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (r_push),
    .push_data_i (r_push_data),
    .full_o      (r_full),
    .pop_i       (m_axi_rready),
    .pop_data_o  (r_pop_data),
    .empty_o     (r_empty)
  );

  noc_resp_fifo #(.WIDTH(AXI_RESP_WIDTH), .DEPTH(B_FIFO_DEPTH)) u_b_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (b_push),
    .push_data_i (AXI_RESP_WIDTH'(AXI_OKAY)),
    .full_o      (b_full),
    .pop_i       (m_axi_bready),
    .pop_data_o  (m_axi_bresp),
    .empty_o     (b_empty)
  );

  assign m_axi_rvalid = !r_empty;
  assign m_axi_bvalid = !b_empty;
  assign {m_axi_rdata, m_axi_rresp} = r_pop_data;

endmodule

// File: tb/tb_noc_resp_axilite_bridge.sv
// Randomised bench for noc_resp_axilite_bridge with a packet-level reference
// model: expected R/B entries are computed when each packet is generated and
// released into the expected queues when the flit that completes them is taken.
module tb_noc_resp_axilite_bridge;
  localparam int NW = 64;
  localparam int AW = 256;
  localparam int NB = AW / NW;
  localparam int RD = 4;
  localparam int BD = 4;
  localparam logic [7:0] T_LOAD  = 8'd24;
  localparam logic [7:0] T_STORE = 8'd25;

  logic          clk = 1'b0;
  logic          rst;
  logic          noc_valid_in;
  logic [NW-1:0] noc_data_in;
  logic          noc_ready_out;
  logic [AW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid;
  logic          m_axi_bready;

  always #5 clk = ~clk;

  noc_resp_axilite_bridge #(
    .NOC_DATA_WIDTH(NW), .AXI_DATA_WIDTH(AW), .AXI_RESP_WIDTH(2),
    .R_FIFO_DEPTH(RD), .B_FIFO_DEPTH(BD)
  ) dut (
    .clk(clk), .rst(rst),
    .noc_valid_in(noc_valid_in), .noc_data_in(noc_data_in), .noc_ready_out(noc_ready_out),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  typedef struct {
    logic [NW-1:0] d;
    bit            last;
    bit            rpush;
    bit            bpush;
    logic [AW-1:0] rdata;
    logic [1:0]    rresp;
  } flit_t;

  typedef struct {
    logic [AW-1:0] d;
    logic [1:0]    r;
  } rent_t;

  flit_t         fq[$];
  rent_t         rq[$];
  logic [1:0]    bq[$];
  bit            in_hdr;
  int            rmode, bmode;   // 0 = hold low, 1 = hold high, 2 = random
  logic [NW-1:0] pl [8];
  int            n_chk, n_fail;

  task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NW-1:0] sw(input logic [NW-1:0] d);
`ifdef NOCRESP_ENDIAN_SWAP_EN
    return {<<8{d}};
`else
    return d;
`endif
  endfunction

  // Queue a packet whose payload is pl[0..len-1]; expected result computed here
  task automatic add_pkt(input logic [7:0] typ, input int len);
    flit_t         f;
    logic [AW-1:0] beat;
    logic [1:0]    resp;
    beat = '0;
    for (int k = 0; k < len && k < NB; k++) beat[k*NW +: NW] = sw(pl[k]);
    resp = (len > NB) ? 2'b10 : 2'b00;
    f.d = {$urandom, $urandom};
    f.d[29:22] = 8'(len);
    f.d[21:14] = typ;
    f.last  = (len == 0);
    f.rpush = (typ == T_LOAD) && (len == 0);
    f.bpush = (typ == T_STORE);
    f.rdata = '0;
    f.rresp = 2'b00;
    fq.push_back(f);
    for (int k = 0; k < len; k++) begin
      f.d     = pl[k];
      f.last  = (k == len - 1);
      f.rpush = (typ == T_LOAD) && (k == len - 1);
      f.bpush = 1'b0;
      f.rdata = beat;
      f.rresp = resp;
      fq.push_back(f);
    end
  endtask

  task automatic rand_payload();
    for (int k = 0; k < 8; k++) pl[k] = {$urandom, $urandom};
  endtask

  function automatic logic pick(input int mode);
    return (mode == 2) ? 1'($urandom_range(1)) : 1'(mode == 1);
  endfunction

  // One clock: check outputs at negedge, drive inputs, advance model at posedge
  task automatic step();
    bit    mrdy;
    flit_t f;
    rent_t re;
    @(negedge clk);
    mrdy = in_hdr ? (rq.size() < RD && bq.size() < BD) : 1'b1;
    check("noc_ready", AW'(noc_ready_out), AW'(mrdy));
    check("rvalid", AW'(m_axi_rvalid), AW'(rq.size() > 0));
    if (rq.size() > 0) begin
      check("rdata", m_axi_rdata, rq[0].d);
      check("rresp", AW'(m_axi_rresp), AW'(rq[0].r));
    end
    check("bvalid", AW'(m_axi_bvalid), AW'(bq.size() > 0));
    if (bq.size() > 0) check("bresp", AW'(m_axi_bresp), AW'(bq[0]));
    noc_valid_in = (fq.size() > 0) && ($urandom_range(3) != 0);
    noc_data_in  = (fq.size() > 0) ? fq[0].d : {$urandom, $urandom};
    m_axi_rready = pick(rmode);
    m_axi_bready = pick(bmode);
    @(posedge clk);
    if (m_axi_rready && rq.size() > 0) void'(rq.pop_front());
    if (m_axi_bready && bq.size() > 0) void'(bq.pop_front());
    if (noc_valid_in && mrdy) begin
      f = fq.pop_front();
      if (f.rpush) begin
        re.d = f.rdata;
        re.r = f.rresp;
        rq.push_back(re);
      end
      if (f.bpush) bq.push_back(2'b00);
      in_hdr = f.last;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input int bound);
    int c;
    c = 0;
    while ((fq.size() > 0 || rq.size() > 0 || bq.size() > 0) && c < bound) begin
      step();
      c++;
    end
    if (c >= bound) check("drain_timeout", AW'(1), AW'(0));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    noc_valid_in = 1'b0;
    repeat (2) @(posedge clk);
    fq.delete();
    rq.delete();
    bq.delete();
    in_hdr = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check({tag, "_rvalid"}, AW'(m_axi_rvalid), AW'(0));
    check({tag, "_bvalid"}, AW'(m_axi_bvalid), AW'(0));
    check({tag, "_rdata"}, m_axi_rdata, AW'(0));
    check({tag, "_rresp"}, AW'(m_axi_rresp), AW'(0));
    check({tag, "_bresp"}, AW'(m_axi_bresp), AW'(0));
  endtask

  initial begin
    int c;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    noc_valid_in = 1'b0;
    noc_data_in = '0;
    m_axi_rready = 1'b0;
    m_axi_bready = 1'b0;
    in_hdr = 1'b1;
    rmode = 1;
    bmode = 1;
    do_reset("reset");

    // Full-width load, short load, overlong load then zero-length store
    pl[0] = 64'h1111_1111_1111_1111; pl[1] = 64'h2222_2222_2222_2222;
    pl[2] = 64'h3333_3333_3333_3333; pl[3] = 64'h4444_4444_4444_4444;
    add_pkt(T_LOAD, 4);
    pl[0] = 64'hAAAA_AAAA_AAAA_AAAA; pl[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    add_pkt(T_LOAD, 2);
    rand_payload();
    add_pkt(T_LOAD, 6);
    add_pkt(T_STORE, 0);
    add_pkt(T_LOAD, 0);
    drain(200);

    // R back-pressure: five single-flit loads against a four-deep queue
    rmode = 0;
    for (int i = 0; i < 5; i++) begin
      rand_payload();
      add_pkt(T_LOAD, 1);
    end
    run(40);
    rmode = 2;
    drain(300);

    // B held while R flows; stores interleaved with loads
    rmode = 1;
    bmode = 0;
    for (int i = 0; i < 3; i++) begin
      rand_payload();
      add_pkt(T_STORE, i);
      add_pkt(T_LOAD, i + 1);
    end
    run(60);
    bmode = 1;
    drain(300);

    // Unknown type is consumed silently
    rand_payload();
    add_pkt(8'd7, 3);
    drain(100);

    // Reset in the middle of a load ack, then a clean packet
    rand_payload();
    add_pkt(T_LOAD, 4);
    c = 0;
    while (fq.size() > 2 && c < 100) begin
      step();
      c++;
    end
    if (c >= 100) check("midpkt_timeout", AW'(1), AW'(0));
    do_reset("midrst");
    rand_payload();
    add_pkt(T_LOAD, 3);
    add_pkt(T_STORE, 1);
    drain(200);

    // Random traffic with shifting ready behaviour
    for (int i = 0; i < 3000; i++) begin
      if (fq.size() < 6) begin
        int sel;
        rand_payload();
        sel = $urandom_range(9);
        if (sel < 5)      add_pkt(T_LOAD, $urandom_range(0, 7));
        else if (sel < 8) add_pkt(T_STORE, $urandom_range(0, 4));
        else              add_pkt(8'($urandom_range(26, 255)), $urandom_range(0, 4));
      end
      if (i % 200 == 0) begin
        rmode = $urandom_range(2);
        bmode = $urandom_range(2);
      end
      step();
    end
    rmode = 1;
    bmode = 1;
    drain(1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_resp_axilite_bridge.md
Name: noc_resp_axilite_bridge

Overview:
- Converts NoC memory-response packets into AXI-Lite master-side read-data (R) and write-response (B) channels.
- Parses header flits and assembles 1..BEATS payload flits into one AXI data word.
- Queues R and B responses in independent, parametrised FIFOs so a stalled R channel does not block store acks already queued.
- Sits between the NoC response port and the AXI-Lite request issuer; generalises the single-channel read-only converter.

Parameters:
- NOC_DATA_WIDTH, 64: NoC flit width in bits.
- AXI_DATA_WIDTH, 256: AXI-Lite data width. Must be an integer multiple of NOC_DATA_WIDTH; BEATS = AXI_DATA_WIDTH/NOC_DATA_WIDTH.
- AXI_RESP_WIDTH, 2: width of rresp/bresp.
- R_FIFO_DEPTH, 4: R queue entries; power of 2, >= 2.
- B_FIFO_DEPTH, 4: B queue entries; power of 2, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- noc_valid_in  in  1  NoC flit valid
- noc_data_in  in  NOC_DATA_WIDTH  NoC flit
- noc_ready_out  out  1  flit accepted when valid&&ready
- m_axi_rdata  out  AXI_DATA_WIDTH  read data
- m_axi_rresp  out  AXI_RESP_WIDTH  read response
- m_axi_rvalid  out  1  R valid
- m_axi_rready  in  1  R ready
- m_axi_bresp  out  AXI_RESP_WIDTH  write response
- m_axi_bvalid  out  1  B valid
- m_axi_bready  in  1  B ready

Behaviour:
- Reset: FSM in HDR; counters cleared; both FIFOs empty. Reset values: rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0. noc_ready_out follows the rules below from the first cycle after reset.
- Header fields: MSG_TYPE and MSG_LENGTH are taken from the codebase-wide NoC header field positions.
- HDR state:
  - noc_ready_out = !r_full && !b_full. This reserves space for the one R or B entry the packet can produce.
  - On header accept: latch type; clear the beat register and flit counter; set the error flag if MSG_LENGTH > BEATS.
  - LOAD_MEM_ACK, length 0: push R entry {data 0, OKAY} on the same edge; stay in HDR.
  - STORE_MEM_ACK: push B entry {OKAY} on the header edge regardless of length.
  - Any other type: no push.
  - If length != 0, go to DATA.
- DATA state:
  - noc_ready_out = 1; every flit is accepted.
  - Flit k (0-based) of a load ack is written to beat bits [k*NOC_DATA_WIDTH +: NOC_DATA_WIDTH] when k < BEATS. Flits with k >= BEATS are discarded.
  - Payload of store acks and unknown types is discarded.
  - On the edge accepting flit k = MSG_LENGTH-1:
    - load ack pushes R entry {beat, error ? SLVERR(2'b10) : OKAY}; unfilled lanes read 0;
    - FSM returns to HDR.
- Latency: an entry is written on the accepting edge; the matching rvalid/bvalid is high in the next cycle (first-word-fall-through FIFO).
- AXI handshake:
  - pop on rvalid&&rready (resp. bvalid&&bready);
  - rdata/rresp and bdata/bresp are stable while valid is high and ready is low;
  - R and B are fully independent.
- Simultaneous push and pop on the same FIFO: both occur; occupancy is unchanged; a full FIFO popping the same cycle still accepts no header. The ready check uses pre-pop full.
- Back-to-back packets: a header may be accepted in the cycle right after the last payload flit. No bubble is required.
- rst asserted mid-packet: the partial beat is lost, queued responses are flushed, and the FSM returns to HDR.

Optional Feature:
- NOCRESP_ENDIAN_SWAP_EN:
  - Defined: each payload flit is byte-reversed within its NOC_DATA_WIDTH lane before being stored in the beat.
  - Undefined: flits are stored unmodified.
- Header parsing is never swapped.

Decomposition:
- Package noc_resp_axilite_pkg holds:
  - FSM state encoding (HDR, DATA);
  - AXI response constants OKAY=2'b00, SLVERR=2'b10;
  - accepted MSG_TYPE codes;
  - the BEATS derivation;
  - a byte-swap function.
- One sub-module, noc_resp_fifo:
  - parameters WIDTH, DEPTH;
  - synchronous first-word-fall-through FIFO with full/empty;
  - instantiated once for R (WIDTH = AXI_DATA_WIDTH+AXI_RESP_WIDTH) and once for B (WIDTH = AXI_RESP_WIDTH).

Test Plan (NOC_DATA_WIDTH=64, AXI_DATA_WIDTH=256):
- Load ack, length 4, flits 0x11..,0x22..,0x33..,0x44.., rready=1 -> one R beat {0x44..,0x33..,0x22..,0x11..} (flit 0 in low lane), rresp=00, rvalid one cycle after the last flit.
- Load ack, length 2 with 0xAAAA_AAAA_AAAA_AAAA, 0xBBBB_BBBB_BBBB_BBBB -> rdata[127:0] holds the flits, rdata[255:128]=0, rresp=00.
- Load ack, length 6 -> all 6 flits accepted, flits 4-5 dropped, rresp=2'b10; a following store ack with length 0 -> bvalid, bresp=00.
- rready=0 with 5 load acks of length 1 (R_FIFO_DEPTH=4) -> noc_ready_out=0 at the 5th header; raising rready for 1 cycle accepts it; data comes out in order.
- Interleaved store ack and load ack with bready=0, rready=1 -> R beat delivered while bvalid is held with stable bresp.
- Unknown MSG_TYPE, length 3 -> 4 flits consumed, no rvalid/bvalid. rst in the middle of a load ack -> both valids 0, the next packet is parsed correctly.
